// File: rtl/adder_nibble_seq_amisha.sv
// Multi-cycle W-bit adder that reuses one 4-bit slice, one nibble per clock, behind a start/busy/done handshake.
// Optional subtract mode (sub_amisha port) is enabled by defining ADDER_NIBBLE_SEQ_SUB_EN.
module adder_nibble_seq_amisha #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk_amisha,
  input  logic                   rst_n_amisha,
  input  logic                   start_amisha,
  input  logic [4*NIBBLES-1:0]   a_amisha,
  input  logic [4*NIBBLES-1:0]   b_amisha,
  input  logic                   cin_amisha,
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  input  logic                   sub_amisha,
`endif
  output logic                   busy_amisha,
  output logic                   done_amisha,
  output logic [4*NIBBLES-1:0]   sum_amisha,
  output logic                   cout_amisha,
  output logic                   ovf_amisha
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  work;
  logic [KW-1:0] k;
  logic          carry;

  logic          sub_eff;
  logic [W-1:0]  b_in;
  logic          c_init;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;
  logic          msb_cin;
  logic [W-1:0]  next_work;

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  assign sub_eff = sub_amisha;
`else
  assign sub_eff = 1'b0;
`endif

  // Subtraction is folded into the capture: B is stored inverted and the carry seeded with 1.
  always_comb begin
    b_in   = sub_eff ? ~b_amisha : b_amisha;
    c_init = sub_eff ? 1'b1 : cin_amisha;
  end

  always_comb begin
    a_nib     = a_reg[{k, 2'b00} +: 4];
    b_nib     = b_reg[{k, 2'b00} +: 4];
    slice     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    msb_cin   = a_nib[3] ^ b_nib[3] ^ slice[3];
    next_work = work;
    next_work[{k, 2'b00} +: 4] = slice[3:0];
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      work        <= '0;
      k           <= '0;
      carry       <= 1'b0;
      busy_amisha <= 1'b0;
      done_amisha <= 1'b0;
      sum_amisha  <= '0;
      cout_amisha <= 1'b0;
      ovf_amisha  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_amisha <= 1'b0;
          if (start_amisha) begin
            a_reg       <= a_amisha;
            b_reg       <= b_in;
            carry       <= c_init;
            k           <= '0;
            busy_amisha <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          work  <= next_work;
          carry <= slice[4];
          k     <= k + KW'(1);
          if (k == LAST) begin
            sum_amisha  <= next_work;
            cout_amisha <= slice[4];
            ovf_amisha  <= msb_cin ^ slice[4];
            busy_amisha <= 1'b0;
            done_amisha <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done_amisha <= 1'b0;
          if (start_amisha) begin
            a_reg       <= a_amisha;
            b_reg       <= b_in;
            carry       <= c_init;
            k           <= '0;
            busy_amisha <= 1'b1;
            state       <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy_amisha <= 1'b0;
          done_amisha <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
